// File: rtl/dct_stage2_col_loader.sv
// dct_stage2_col_loader: accepts eight stage-1 columns, writes them one-hot into the stage-2 bank, then holds the block until acked.
// Define DCT_STAGE2_SAT_EN to clamp coefficients to SIZE bits (and track sat_seen) instead of wrapping them.
module dct_stage2_col_loader #(
   parameter int SIZE    = 12,
   parameter int IN_SIZE = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [IN_SIZE-1:0]  in_data [7:0],
   output logic [7:0]                 wr_en,
   output logic signed [SIZE-1:0]     col_data [7:0],
   output logic                       blk_valid,
   input  logic                       blk_ack,
   output logic [7:0]                 blk_cnt,
   output logic                       sat_seen
);
   typedef enum logic [1:0] {FILL, DRAIN, FULL} state_t;
   state_t                 state, state_nx;
   logic [2:0]             col_cnt;
   logic                   accept;
   logic signed [SIZE-1:0] conv [7:0];
`ifdef DCT_STAGE2_SAT_EN
   localparam int MAX_I = 2 ** (SIZE - 1) - 1;
   localparam int MIN_I = -MAX_I - 1;
   logic [7:0] clip;
`endif
   always_comb begin
      in_ready  = (state == FILL);
      blk_valid = (state == FULL);
      accept    = in_ready && in_valid;
      state_nx  = state;
      case (state)
         FILL:    state_nx = (accept && col_cnt == 3'd7) ? DRAIN : FILL;
         DRAIN:   state_nx = FULL;
         FULL:    state_nx = blk_ack ? FILL : FULL;
         default: state_nx = FILL;
      endcase
   end
   // Per-element narrowing from IN_SIZE to SIZE ahead of the col_data register
   always_comb begin
`ifdef DCT_STAGE2_SAT_EN
      clip = '0;
`endif
      for (int i = 0; i < 8; i++) begin
`ifdef DCT_STAGE2_SAT_EN
         clip[i] = (in_data[i] > MAX_I) || (in_data[i] < MIN_I);
         conv[i] = (in_data[i] > MAX_I) ? SIZE'(MAX_I) :
                   (in_data[i] < MIN_I) ? SIZE'(MIN_I) : in_data[i][SIZE-1:0];
`else
         conv[i] = in_data[i][SIZE-1:0];
`endif
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= FILL;
         col_cnt <= '0;
         wr_en   <= '0;
         blk_cnt <= '0;
         for (int i = 0; i < 8; i++) col_data[i] <= '0;
      end else begin
         state <= state_nx;
         wr_en <= accept ? (8'd1 << col_cnt) : 8'd0;
         if (accept) begin
            col_cnt  <= col_cnt + 3'd1;
            col_data <= conv;
         end
         if (state == FULL && blk_ack) blk_cnt <= blk_cnt + 8'd1;
      end
   end
`ifdef DCT_STAGE2_SAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sat_seen <= 1'b0;
      else if (accept && |clip) sat_seen <= 1'b1;
   end
`else
   assign sat_seen = 1'b0;
`endif
endmodule

// File: tb/tb_dct_stage2_col_loader.sv
// tb_dct_stage2_col_loader: randomized bench for dct_stage2_col_loader against a beat-counting block model.
// Honours DCT_STAGE2_SAT_EN the same way the design does.
module tb_dct_stage2_col_loader;
   localparam int SIZE = 12;
   localparam int IN_SIZE = 16;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic blk_ack = 1'b0;
   logic in_ready, blk_valid, sat_seen;
   logic [7:0] wr_en, blk_cnt;
   logic signed [IN_SIZE-1:0] in_data [7:0];
   logic signed [SIZE-1:0] col_data [7:0];
   int n_chk = 0;
   int n_fail = 0;
   // model: beats taken into the current block, block visible flag, last write, stored column
   int m_beats, m_blk;
   bit m_full, m_sat;
   logic [7:0] m_wr;
   int m_col [8];

   always #5 clk = ~clk;

   dct_stage2_col_loader #(.SIZE(SIZE), .IN_SIZE(IN_SIZE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .wr_en(wr_en), .col_data(col_data), .blk_valid(blk_valid), .blk_ack(blk_ack),
      .blk_cnt(blk_cnt), .sat_seen(sat_seen)
   );

   function automatic int conv(int x);
      int hi = (1 <<< (SIZE - 1)) - 1;
`ifdef DCT_STAGE2_SAT_EN
      return x > hi ? hi : (x < -hi - 1 ? -hi - 1 : x);
`else
      int m = 1 <<< SIZE;
      int w = ((x % m) + m) % m;
      return w > hi ? w - m : w;
`endif
   endfunction

   function automatic bit clips(int x);
`ifdef DCT_STAGE2_SAT_EN
      return conv(x) != x;
`else
      return (x != x);
`endif
   endfunction

   task automatic model_reset();
      m_beats = 0; m_full = 0; m_wr = '0; m_blk = 0; m_sat = 0;
      foreach (m_col[r]) m_col[r] = 0;
   endtask

   task automatic rand_data(output int d[8]);
      for (int r = 0; r < 8; r++)
         d[r] = ($urandom_range(1) != 0) ? int'($urandom_range(65535)) - 32768
                                         : int'($urandom_range(4095)) - 2048;
   endtask

   task automatic tick(input bit v, input bit ack, input int d[8]);
      in_valid = v;
      blk_ack = ack;
      for (int r = 0; r < 8; r++) in_data[r] = IN_SIZE'(d[r]);
      m_wr = '0;
      if (m_beats < 8 && v) begin
         m_wr = 8'(1 << m_beats);
         for (int r = 0; r < 8; r++) begin
            m_col[r] = conv(d[r]);
            if (clips(d[r])) m_sat = 1;
         end
         m_beats++;
      end else if (m_beats == 8 && !m_full) m_full = 1;
      else if (m_full && ack) begin
         m_full = 0; m_beats = 0; m_blk = (m_blk + 1) % 256;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int z[8] = '{default: 0};
      model_reset();
      #3;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      n_chk++; if (wr_en !== 8'h00 || blk_valid !== 1'b0 || blk_cnt !== 8'h00 || sat_seen !== 1'b0) begin
         n_fail++; $display("FAIL reset_outs: wr_en=%h blk_valid=%b blk_cnt=%h sat=%b want 0", wr_en, blk_valid, blk_cnt, sat_seen);
      end
      for (int r = 0; r < 8; r++) begin
         n_chk++; if (col_data[r] !== '0) begin n_fail++; $display("FAIL reset_col[%0d]: got %0d want 0", r, col_data[r]); end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      tick(0, 0, z);
      n_chk++; if (in_ready !== 1'b1 || wr_en !== 8'h00) begin
         n_fail++; $display("FAIL post_reset: ready=%b wr_en=%h want 1/00", in_ready, wr_en);
      end
   endtask

   task automatic test_fill();
      int d[8];
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 8; r++) d[r] = 8 * c + r;
         tick(1, 0, d);
         n_chk++; if (wr_en !== 8'(1 << c) || wr_en !== m_wr) begin
            n_fail++; $display("FAIL fill_wr_en c=%0d: got %h want %h", c, wr_en, 8'(1 << c));
         end
         for (int r = 0; r < 8; r++) begin
            n_chk++; if (int'(col_data[r]) !== 8 * c + r) begin
               n_fail++; $display("FAIL fill_col c=%0d r=%0d: got %0d want %0d", c, r, col_data[r], 8 * c + r);
            end
         end
         n_chk++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL fill_blk_valid c=%0d: got %b want 0", c, blk_valid); end
      end
      tick(0, 0, d);
      n_chk++; if (blk_valid !== 1'b1 || in_ready !== 1'b0 || wr_en !== 8'h00) begin
         n_fail++; $display("FAIL fill_full: blk_valid=%b ready=%b wr_en=%h want 1/0/00", blk_valid, in_ready, wr_en);
      end
   endtask

   task automatic test_hold();
      int d[8];
      for (int i = 0; i < 20; i++) begin
         rand_data(d);
         tick(1, 0, d);
         n_chk++; if (in_ready !== 1'b0 || wr_en !== 8'h00 || blk_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold i=%0d: ready=%b wr_en=%h blk_valid=%b want 0/00/1", i, in_ready, wr_en, blk_valid);
         end
      end
      tick(0, 1, d);
      n_chk++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL ack_release: blk_valid=%b ready=%b want 0/1", blk_valid, in_ready);
      end
      n_chk++; if (blk_cnt !== 8'd1 || blk_cnt !== 8'(m_blk)) begin
         n_fail++; $display("FAIL ack_blk_cnt: got %0d want 1", blk_cnt);
      end
   endtask

   task automatic test_mid_reset();
      int d[8];
      for (int i = 0; i < 3; i++) begin rand_data(d); tick(1, 0, d); end
      #2 rst = 1'b0;
      model_reset();
      #1;
      n_chk++; if (wr_en !== 8'h00 || blk_valid !== 1'b0 || blk_cnt !== 8'h00 || sat_seen !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset: wr_en=%h blk_valid=%b blk_cnt=%h sat=%b ready=%b", wr_en, blk_valid, blk_cnt, sat_seen, in_ready);
      end
      for (int r = 0; r < 8; r++) begin
         n_chk++; if (col_data[r] !== '0) begin n_fail++; $display("FAIL mid_reset_col[%0d]: got %0d want 0", r, col_data[r]); end
      end
      #2 rst = 1'b1;
      rand_data(d);
      tick(1, 0, d);
      n_chk++; if (wr_en !== 8'h01 || wr_en !== m_wr) begin
         n_fail++; $display("FAIL after_reset_col0: wr_en got %h want 01", wr_en);
      end
   endtask

   task automatic test_sat();
      int d[8];
      int want [3];
`ifdef DCT_STAGE2_SAT_EN
      want = '{2047, -2048, 100};
`else
      want = '{-96, -904, 100};
`endif
      rand_data(d);
      d[0] = 4000; d[1] = -5000; d[2] = 100;
      tick(1, 0, d);
      for (int r = 0; r < 3; r++) begin
         n_chk++; if (int'(col_data[r]) !== want[r] || int'(col_data[r]) !== m_col[r]) begin
            n_fail++; $display("FAIL sat_col[%0d]: got %0d want %0d", r, col_data[r], want[r]);
         end
      end
`ifdef DCT_STAGE2_SAT_EN
      n_chk++; if (sat_seen !== 1'b1) begin n_fail++; $display("FAIL sat_seen: got %b want 1", sat_seen); end
`else
      n_chk++; if (sat_seen !== 1'b0) begin n_fail++; $display("FAIL sat_seen: got %b want 0", sat_seen); end
`endif
   endtask

   task automatic test_random();
      int d[8];
      for (int i = 0; i < 400; i++) begin
         rand_data(d);
         tick($urandom_range(9) < 7, $urandom_range(9) < 3, d);
         n_chk++; if (in_ready !== 1'(m_beats < 8) || blk_valid !== 1'(m_full) || wr_en !== m_wr) begin
            n_fail++; $display("FAIL rand_ctl i=%0d: ready=%b blk_valid=%b wr_en=%h want %b/%b/%h",
                               i, in_ready, blk_valid, wr_en, m_beats < 8, m_full, m_wr);
         end
         n_chk++; if (blk_cnt !== 8'(m_blk) || sat_seen !== m_sat) begin
            n_fail++; $display("FAIL rand_cnt i=%0d: blk_cnt=%0d sat=%b want %0d/%b", i, blk_cnt, sat_seen, m_blk, m_sat);
         end
         for (int r = 0; r < 8; r++) begin
            n_chk++; if (int'(col_data[r]) !== m_col[r]) begin
               n_fail++; $display("FAIL rand_col i=%0d r=%0d: got %0d want %0d", i, r, col_data[r], m_col[r]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int d[8];
      int last = -1;
      rst = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      for (int i = 0; i < 2560; i++) begin
         rand_data(d);
         tick(1, 1, d);
         n_chk++; if (wr_en !== m_wr || blk_valid !== 1'(m_full) || in_ready !== 1'(m_beats < 8)) begin
            n_fail++; $display("FAIL b2b i=%0d: wr_en=%h blk_valid=%b ready=%b want %h/%b/%b",
                               i, wr_en, blk_valid, in_ready, m_wr, m_full, m_beats < 8);
         end
         if (wr_en === 8'h80) begin
            n_chk++; if (last >= 0 && i - last !== 10) begin
               n_fail++; $display("FAIL b2b_period i=%0d: got %0d want 10", i, i - last);
            end
            last = i;
         end
      end
      n_chk++; if (blk_cnt !== 8'd0 || m_blk !== 0) begin
         n_fail++; $display("FAIL b2b_wrap: blk_cnt got %0d want 0", blk_cnt);
      end
   endtask

   initial begin
      for (int r = 0; r < 8; r++) in_data[r] = '0;
      test_reset();
      test_fill();
      test_hold();
      test_mid_reset();
      test_sat();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
